// File: rtl/arcade_input_mapper.sv
// Player-input front end for arcade cores. PS/2 key events go through a
// runtime-loadable keymap RAM into per-button hold counters. The result is
// merged with the HPS joystick bits, then SOCD resolution, autofire and coin
// stretching are applied before the registered button output.
// The keymap has no reset and no power-up clear. The host loader must write
// every entry before relying on it (all zeros means all entries invalid).
module arcade_input_mapper #(
  parameter int unsigned PLAYERS   = 2,
  parameter int unsigned BUTTONS   = 16,
  parameter int unsigned COIN_IDX  = 15,
  parameter logic [15:0] COIN_HOLD = 16'd48000
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic [10:0]                ps2_key,
  input  logic [PLAYERS*BUTTONS-1:0] joy_in,
  input  logic                       map_wr,
  input  logic [8:0]                 map_addr,
  input  logic [7:0]                 map_data,
  input  logic                       kbd_clear,
  input  logic [PLAYERS*BUTTONS-1:0] autofire_en,
  input  logic [15:0]                af_half_period,
  input  logic [1:0]                 socd_mode,
  output logic [PLAYERS*BUTTONS-1:0] btn_out,
  output logic                       unmapped
);

  localparam int unsigned NB = PLAYERS * BUTTONS;

  // Resolve one opposing pair. Returns {last_hi_next, hi_out, lo_out}.
  // last_hi records which side had the most recent rising edge.
  function automatic logic [2:0] socd_pair(input logic [1:0] mode, input logic lo, input logic hi,
                                           input logic lo_prev, input logic hi_prev,
                                           input logic last_hi, input logic pref_hi);
    logic       rise_lo, rise_hi, nxt;
    logic [1:0] o;
    rise_lo = lo & ~lo_prev;
    rise_hi = hi & ~hi_prev;
    if (rise_lo && rise_hi) nxt = pref_hi;
    else if (rise_lo)       nxt = 1'b0;
    else if (rise_hi)       nxt = 1'b1;
    else                    nxt = last_hi;
    o = {hi, lo};
    if (lo && hi) begin
      if (mode == 2'd1)      o = 2'b00;
      else if (mode == 2'd2) o = nxt ? 2'b10 : 2'b01;
    end
    return {nxt, o};
  endfunction

  // ---------------------------------------------------------------------------
  // Keymap RAM and event capture (C0)
  // ---------------------------------------------------------------------------
  logic [7:0] keymap [512];
  logic [7:0] ent_q;

  // Read-before-write RAM: a same-address read in the write cycle sees old data.
  always_ff @(posedge clk_sys) begin
    if (map_wr) keymap[map_addr] <= map_data;
    ent_q <= keymap[ps2_key[8:0]];
  end

  logic       toggle_q;
  logic       ev_valid_q;
  logic       ev_pressed_q;
  logic [8:0] ev_addr_q;

  // Detect a toggle on ps2_key[10] and latch the event alongside the RAM read.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      toggle_q     <= ps2_key[10];
      ev_valid_q   <= 1'b0;
      ev_pressed_q <= 1'b0;
      ev_addr_q    <= '0;
    end else begin
      toggle_q     <= ps2_key[10];
      ev_valid_q   <= (ps2_key[10] != toggle_q);
      ev_pressed_q <= ps2_key[9];
      ev_addr_q    <= ps2_key[8:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Keymap lookup result (C1)
  // ---------------------------------------------------------------------------
  logic [511:0] bitmap_q;
  logic [2:0]   hold_q [NB];
  logic [2:0]   ent_player;
  logic [3:0]   ent_button;
  logic         ent_ok;
  logic         press_new;
  logic         release_old;
  int           ev_idx;

  // Decode the looked-up entry and decide whether the event changes key state.
  always_comb begin
    ent_player  = ent_q[6:4];
    ent_button  = ent_q[3:0];
    ent_ok      = ent_q[7] && (32'(ent_player) < PLAYERS) && (32'(ent_button) < BUTTONS);
    ev_idx      = int'(ent_player) * int'(BUTTONS) + int'(ent_button);
    press_new   = ev_valid_q && ent_ok && !kbd_clear && ev_pressed_q && !bitmap_q[ev_addr_q];
    release_old = ev_valid_q && ent_ok && !kbd_clear && !ev_pressed_q && bitmap_q[ev_addr_q];
    unmapped    = ev_valid_q && !ent_ok && !kbd_clear;
  end

  // Pressed-key bitmap and per-button hold counters; a counter tracks how many
  // distinct keys currently hold its button (saturating 0..7).
  always_ff @(posedge clk_sys) begin
    if (reset || kbd_clear) begin
      bitmap_q <= '0;
      for (int i = 0; i < int'(NB); i++) hold_q[i] <= '0;
    end else begin
      if (press_new)   bitmap_q[ev_addr_q] <= 1'b1;
      if (release_old) bitmap_q[ev_addr_q] <= 1'b0;
      for (int i = 0; i < int'(NB); i++) begin
        if (i == ev_idx) begin
          if (press_new && hold_q[i] != 3'd7)   hold_q[i] <= hold_q[i] + 3'd1;
          if (release_old && hold_q[i] != 3'd0) hold_q[i] <= hold_q[i] - 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Merge with joystick
  // ---------------------------------------------------------------------------
  logic [NB-1:0] joy_in_q;
  logic [NB-1:0] hold_nz;
  logic [NB-1:0] raw;

  // Register the joystick bits once before merging.
  always_ff @(posedge clk_sys) begin
    if (reset) joy_in_q <= '0;
    else       joy_in_q <= joy_in;
  end

  // Raw button state: joystick OR any key holding the button.
  always_comb begin
    hold_nz = '0;
    for (int i = 0; i < int'(NB); i++) hold_nz[i] = (hold_q[i] != 3'd0);
    raw = joy_in_q | hold_nz;
  end

  // ---------------------------------------------------------------------------
  // Autofire timebase
  // ---------------------------------------------------------------------------
  logic [15:0] af_cnt_q;
  logic [15:0] af_half_q;
  logic        af_phase_q;
  logic        af_phase;

  // Count 0..af_half_period then toggle the phase; a new period restarts the count.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt_q   <= '0;
      af_half_q  <= af_half_period;
      af_phase_q <= 1'b1;
    end else begin
      af_half_q <= af_half_period;
      if (af_half_period == 16'd0) begin
        af_cnt_q   <= '0;
        af_phase_q <= 1'b1;
      end else if (af_half_period != af_half_q) begin
        af_cnt_q <= '0;
      end else if (af_cnt_q == af_half_period) begin
        af_cnt_q   <= '0;
        af_phase_q <= ~af_phase_q;
      end else begin
        af_cnt_q <= af_cnt_q + 16'd1;
      end
    end
  end

  assign af_phase = (af_half_period == 16'd0) || af_phase_q;

  // ---------------------------------------------------------------------------
  // SOCD, autofire, coin stretch
  // ---------------------------------------------------------------------------
  logic [15:0]        pr_pl       [PLAYERS];
  logic [15:0]        sp_pl       [PLAYERS];
  logic [3:0]         dir_q       [PLAYERS];
  logic [1:0]         last_hi_q   [PLAYERS];
  logic [1:0]         last_hi_d   [PLAYERS];
  logic [15:0]        coin_tmr_q  [PLAYERS];
  logic [15:0]        coin_tmr_d  [PLAYERS];
  logic [PLAYERS-1:0] coin_prev_q;
  logic [PLAYERS-1:0] coin_now;
  logic [NB-1:0]      btn_d;
  logic [NB-1:0]      btn_q;

  // Per player: pad to 16 bits, resolve the two opposing pairs, then apply
  // coin stretching to COIN_IDX and autofire to every other enabled bit.
  always_comb begin
    btn_d    = '0;
    coin_now = '0;
    for (int p = 0; p < int'(PLAYERS); p++) begin
      pr_pl[p] = '0;
      for (int b = 0; b < int'(BUTTONS); b++) pr_pl[p][b] = raw[p * int'(BUTTONS) + b];
      sp_pl[p] = pr_pl[p];
      {last_hi_d[p][0], sp_pl[p][1:0]} = socd_pair(socd_mode, pr_pl[p][0], pr_pl[p][1],
                                                   dir_q[p][0], dir_q[p][1],
                                                   last_hi_q[p][0], 1'b0);
      {last_hi_d[p][1], sp_pl[p][3:2]} = socd_pair(socd_mode, pr_pl[p][2], pr_pl[p][3],
                                                   dir_q[p][2], dir_q[p][3],
                                                   last_hi_q[p][1], 1'b1);
      coin_tmr_d[p] = (coin_tmr_q[p] != 16'd0) ? coin_tmr_q[p] - 16'd1 : 16'd0;
      for (int b = 0; b < int'(BUTTONS); b++) begin
        if (b == int'(COIN_IDX)) begin
          coin_now[p] = sp_pl[p][b];
          if (sp_pl[p][b] && !coin_prev_q[p]) coin_tmr_d[p] = COIN_HOLD;
          // Using the next timer value makes the pulse exactly COIN_HOLD cycles.
          btn_d[p * int'(BUTTONS) + b] = sp_pl[p][b] || (coin_tmr_d[p] != 16'd0);
        end else begin
          btn_d[p * int'(BUTTONS) + b] = sp_pl[p][b] &&
                                         (!autofire_en[p * int'(BUTTONS) + b] || af_phase);
        end
      end
    end
  end

  // Output register plus the history the SOCD and coin edge detectors need.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_q       <= '0;
      coin_prev_q <= '0;
      for (int p = 0; p < int'(PLAYERS); p++) begin
        dir_q[p]      <= '0;
        last_hi_q[p]  <= '0;
        coin_tmr_q[p] <= '0;
      end
    end else begin
      btn_q       <= btn_d;
      coin_prev_q <= coin_now;
      for (int p = 0; p < int'(PLAYERS); p++) begin
        dir_q[p]      <= pr_pl[p][3:0];
        last_hi_q[p]  <= last_hi_d[p];
        coin_tmr_q[p] <= coin_tmr_d[p];
      end
    end
  end

  assign btn_out = btn_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed sequences, an SOCD vector table and
// a randomized keyboard/joystick run against a key-set reference model.
module tb_arcade_input_mapper;

  localparam int NR = 300;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [31:0] joy_in;
  logic        map_wr;
  logic [8:0]  map_addr;
  logic [7:0]  map_data;
  logic        kbd_clear;
  logic [31:0] autofire_en;
  logic [15:0] af_half_period;
  logic [1:0]  socd_mode;
  logic [31:0] btn_out;
  logic        unmapped;

  arcade_input_mapper #(
    .PLAYERS  (2),
    .BUTTONS  (16),
    .COIN_IDX (15),
    .COIN_HOLD(16'd20)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .ps2_key       (ps2_key),
    .joy_in        (joy_in),
    .map_wr        (map_wr),
    .map_addr      (map_addr),
    .map_data      (map_data),
    .kbd_clear     (kbd_clear),
    .autofire_en   (autofire_en),
    .af_half_period(af_half_period),
    .socd_mode     (socd_mode),
    .btn_out       (btn_out),
    .unmapped      (unmapped)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_err    = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic map_set(input logic [8:0] a, input logic [7:0] d);
    map_wr   = 1'b1;
    map_addr = a;
    map_data = d;
    tick();
    map_wr   = 1'b0;
  endtask

  task automatic key(input logic pressed, input logic [8:0] a);
    ps2_key = {~ps2_key[10], pressed, a};
    tick();
  endtask

  typedef struct packed {
    logic       player;
    logic [1:0] mode;
    logic [3:0] joy;
    logic [3:0] exp;
  } socd_vec_t;

  socd_vec_t   tv [13];
  logic        s [40];
  int          bad, runs, first, cnt;
  logic        ok;
  logic [31:0] exp32;
  logic [8:0]  rk [7];
  int          rp [6];
  int          rb [6];
  bit          held [6];
  logic [31:0] joy_h [NR+3];
  logic [31:0] kb_h [NR+3];
  logic        un_h [NR+3];
  logic [31:0] jv, mask;
  logic        un;
  int          k;
  logic        kp;

  initial begin
    tv[0]  = '{1'b0, 2'd0, 4'b0011, 4'b0011};
    tv[1]  = '{1'b0, 2'd3, 4'b1100, 4'b1100};
    tv[2]  = '{1'b0, 2'd1, 4'b0011, 4'b0000};
    tv[3]  = '{1'b0, 2'd1, 4'b1100, 4'b0000};
    tv[4]  = '{1'b0, 2'd1, 4'b0101, 4'b0101};
    tv[5]  = '{1'b0, 2'd1, 4'b1111, 4'b0000};
    tv[6]  = '{1'b0, 2'd2, 4'b0011, 4'b0001};
    tv[7]  = '{1'b0, 2'd2, 4'b1100, 4'b1000};
    tv[8]  = '{1'b0, 2'd2, 4'b1111, 4'b1001};
    tv[9]  = '{1'b1, 2'd2, 4'b0110, 4'b0110};
    tv[10] = '{1'b1, 2'd1, 4'b1111, 4'b0000};
    tv[11] = '{1'b1, 2'd2, 4'b1111, 4'b1001};
    tv[12] = '{1'b1, 2'd0, 4'b1111, 4'b1111};

    reset          = 1'b1;
    ps2_key        = '0;
    joy_in         = '0;
    map_wr         = 1'b0;
    map_addr       = '0;
    map_data       = '0;
    kbd_clear      = 1'b0;
    autofire_en    = '0;
    af_half_period = '0;
    socd_mode      = 2'd0;
    tick(3);
    check("reset btn_out", btn_out, 0);
    check("reset unmapped", unmapped, 0);
    reset = 1'b0;

    for (int a = 0; a < 512; a++) map_set(9'(a), 8'h00);

    // SOCD vector table
    for (int i = 0; i < 13; i++) begin
      socd_mode = tv[i].mode;
      joy_in    = '0;
      tick(3);
      joy_in[int'(tv[i].player)*16 +: 4] = tv[i].joy;
      tick(2);
      exp32 = 32'(tv[i].exp) << (int'(tv[i].player) * 16);
      check($sformatf("socd vec %0d", i), btn_out, exp32);
    end
    joy_in    = '0;
    socd_mode = 2'd0;
    tick(3);

    // Single key, 3-cycle latency
    map_set(9'h075, 8'h83);
    key(1'b1, 9'h075);
    tick();
    check("key press +2", btn_out[3], 0);
    tick();
    check("key press +3", btn_out[3], 1);
    key(1'b0, 9'h075);
    tick();
    check("key release +2", btn_out[3], 1);
    tick();
    check("key release +3", btn_out[3], 0);

    // Two keys on one button, typematic repeats
    map_set(9'h014, 8'h84);
    map_set(9'h029, 8'h84);
    key(1'b1, 9'h014);
    key(1'b1, 9'h029);
    tick(3);
    check("two keys held", btn_out[4], 1);
    key(1'b0, 9'h014);
    tick(3);
    check("one of two released", btn_out[4], 1);
    key(1'b0, 9'h029);
    tick(3);
    check("both released", btn_out[4], 0);
    repeat (5) key(1'b1, 9'h014);
    tick(3);
    check("typematic held", btn_out[4], 1);
    key(1'b0, 9'h014);
    tick(3);
    check("typematic single release", btn_out[4], 0);

    // Unmapped entries
    key(1'b1, 9'h055);
    check("unmapped pulse invalid", unmapped, 1);
    tick();
    check("unmapped one cycle", unmapped, 0);
    tick(2);
    check("unmapped btn unchanged", btn_out, 0);
    map_set(9'h056, 8'hD0);
    key(1'b1, 9'h056);
    check("unmapped pulse player5", unmapped, 1);
    tick();
    check("unmapped player5 one cycle", unmapped, 0);
    tick(2);
    check("player5 btn unchanged", btn_out, 0);

    // SOCD last-wins sequence
    socd_mode = 2'd2;
    tick(3);
    joy_in[1] = 1'b1;
    tick(10);
    check("socd left alone", btn_out[1:0], 2'b10);
    joy_in[0] = 1'b1;
    tick(2);
    check("socd right wins", btn_out[1:0], 2'b01);
    joy_in[0] = 1'b0;
    tick();
    check("socd right drop +1", btn_out[1:0], 2'b01);
    tick();
    check("socd left reasserts", btn_out[1:0], 2'b10);
    socd_mode = 2'd1;
    joy_in[0] = 1'b1;
    tick(2);
    check("socd neutral both", btn_out[1:0], 2'b00);
    joy_in    = '0;
    socd_mode = 2'd0;
    tick(3);

    // Autofire
    af_half_period = 16'd3;
    autofire_en[4] = 1'b1;
    joy_in[4]      = 1'b1;
    tick(6);
    for (int i = 0; i < 40; i++) begin
      s[i] = btn_out[4];
      tick();
    end
    bad   = 0;
    runs  = 0;
    first = -1;
    for (int i = 1; i < 40; i++) begin
      if (s[i] != s[i-1]) begin
        if (first >= 0) begin
          runs++;
          if (i - first != 4) bad++;
        end
        first = i;
      end
    end
    check("autofire bad run lengths", bad, 0);
    check("autofire enough runs", (runs >= 8), 1);
    af_half_period = 16'd0;
    tick(2);
    ok = 1'b1;
    repeat (10) begin
      ok = ok & btn_out[4];
      tick();
    end
    check("autofire off steady", ok, 1);
    joy_in      = '0;
    autofire_en = '0;
    tick(3);

    // Coin stretch
    joy_in[15] = 1'b1;
    tick();
    joy_in[15] = 1'b0;
    cnt = 0;
    repeat (40) begin
      tick();
      cnt += int'(btn_out[15]);
    end
    check("coin stretch length", cnt, 20);

    // kbd_clear with keys held, joystick unaffected
    joy_in[6] = 1'b1;
    key(1'b1, 9'h075);
    key(1'b1, 9'h014);
    tick(3);
    check("pre-clear bits", btn_out[6:3], 4'b1011);
    kbd_clear = 1'b1;
    tick();
    kbd_clear = 1'b0;
    tick();
    check("post-clear bits", btn_out[6:3], 4'b1000);

    // Randomized run against a key-set model
    joy_in = '0;
    reset  = 1'b1;
    tick(2);
    reset = 1'b0;
    rk[0] = 9'h01c; rk[1] = 9'h01b; rk[2] = 9'h123; rk[3] = 9'h12b;
    rk[4] = 9'h034; rk[5] = 9'h133; rk[6] = 9'h04b;
    for (int i = 0; i < 6; i++) begin
      rp[i]   = int'($urandom_range(0, 1));
      rb[i]   = int'($urandom_range(0, 14));
      held[i] = 1'b0;
      map_set(rk[i], {1'b1, 3'(rp[i]), 4'(rb[i])});
    end
    map_set(rk[6], 8'h00);
    for (int i = 0; i < 3; i++) begin
      joy_h[i] = '0;
      kb_h[i]  = '0;
      un_h[i]  = 1'b0;
    end
    for (int j = 0; j < NR; j++) begin
      jv     = $urandom() & 32'h7fff_7fff;
      joy_in = jv;
      un     = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        k       = int'($urandom_range(0, 6));
        kp      = 1'($urandom_range(0, 1));
        ps2_key = {~ps2_key[10], kp, rk[k]};
        if (k == 6) un = 1'b1;
        else        held[k] = kp;
      end
      mask = '0;
      for (int i = 0; i < 6; i++) if (held[i]) mask |= 32'd1 << (rp[i] * 16 + rb[i]);
      joy_h[j+3] = jv;
      kb_h[j+3]  = mask;
      un_h[j+3]  = un;
      tick();
      check($sformatf("random cycle %0d", j), {unmapped, btn_out},
            {un_h[j+3], joy_h[j+2] | kb_h[j+1]});
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
